// File: rtl/wsn_mem_pkg.sv
// wsn_mem_pkg: shared definitions for the node data memory.
//   - default geometry (word size, byte depth)
//   - byte-address bases of the protocol regions held in the memory
//   - controller state type
package wsn_mem_pkg;

  localparam int unsigned DEF_WORD_BYTES = 2;
  localparam int unsigned DEF_MEM_DEPTH  = 2048;

  // Region base byte addresses
  localparam logic [10:0] RGN_FLAGS          = 11'h000;
  localparam logic [10:0] RGN_KNOWN_SINKS    = 11'h008;
  localparam logic [10:0] RGN_WORST_HOPS     = 11'h028;
  localparam logic [10:0] RGN_NEIGHBOR_ID    = 11'h048;
  localparam logic [10:0] RGN_CLUSTER_ID     = 11'h0C8;
  localparam logic [10:0] RGN_BATTERY        = 11'h148;
  localparam logic [10:0] RGN_QVALUE         = 11'h1C8;
  localparam logic [10:0] RGN_SINK_IDS       = 11'h248;
  localparam logic [10:0] RGN_HCM            = 11'h648;
  localparam logic [10:0] RGN_BETTER_NB      = 11'h668;
  localparam logic [10:0] RGN_KNOWN_SINK_CNT = 11'h688;
  localparam logic [10:0] RGN_NEIGHBOR_CNT   = 11'h68A;
  localparam logic [10:0] RGN_BETTER_NB_CNT  = 11'h68C;
  localparam logic [10:0] RGN_SINK_ID_CNT    = 11'h68E;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } mem_state_t;

endpackage

// File: rtl/wsn_mem_lane.sv
// wsn_mem_lane: combinational big-endian byte-lane conversion and range check
// for one memory port.
//   addr      : byte address of the most significant byte
//   wdata     : big-endian write word
//   mem_bytes : memory bytes addr..addr+WORD_BYTES-1, lane i at [i*BYTE_W +: BYTE_W]
//   wr_bytes  : wdata split into the same lane layout as mem_bytes
//   rword     : mem_bytes packed into a big-endian word
//   oor       : access would run past the end of the memory
module wsn_mem_lane
  import wsn_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES,
  parameter int unsigned ADDR_W     = 11
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [BYTE_W*WORD_BYTES-1:0] wdata,
  input  logic [BYTE_W*WORD_BYTES-1:0] mem_bytes,
  output logic [BYTE_W*WORD_BYTES-1:0] wr_bytes,
  output logic [BYTE_W*WORD_BYTES-1:0] rword,
  output logic                         oor
);

  // One extra bit so addr + WORD_BYTES never wraps past zero.
  logic [ADDR_W:0] end_addr;

  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_byte
    assign wr_bytes[i*BYTE_W +: BYTE_W]                = wdata[(WORD_BYTES-1-i)*BYTE_W +: BYTE_W];
    assign rword[(WORD_BYTES-1-i)*BYTE_W +: BYTE_W]    = mem_bytes[i*BYTE_W +: BYTE_W];
  end

  assign end_addr = {1'b0, addr} + (ADDR_W+1)'(WORD_BYTES);
  assign oor      = end_addr > (ADDR_W+1)'(MEM_DEPTH);

endmodule

// File: rtl/wsn_mem_dp.sv
// wsn_mem_dp: dual-port byte-addressed node data memory, big-endian words.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata -> a_ready, a_rvalid, a_rdata, a_err : read/write port
//   b_req/b_addr          -> b_ready, b_rvalid, b_rdata, b_err     : read-only port
//   busy                  : post-reset clear sweep in progress
// Reads return registered data one cycle after acceptance. Out-of-range
// accesses touch no memory and pulse err with zero rdata.
module wsn_mem_dp
  import wsn_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned WORD_BYTES     = DEF_WORD_BYTES,
  parameter int unsigned ADDR_W         = 11,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         a_req,
  input  logic                         a_we,
  input  logic [ADDR_W-1:0]            a_addr,
  input  logic [BYTE_W*WORD_BYTES-1:0] a_wdata,
  output logic                         a_ready,
  output logic                         a_rvalid,
  output logic [BYTE_W*WORD_BYTES-1:0] a_rdata,
  output logic                         a_err,
  input  logic                         b_req,
  input  logic [ADDR_W-1:0]            b_addr,
  output logic                         b_ready,
  output logic                         b_rvalid,
  output logic [BYTE_W*WORD_BYTES-1:0] b_rdata,
  output logic                         b_err,
  output logic                         busy
);

  localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [BYTE_W-1:0] mem [MEM_DEPTH];

  mem_state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q;

  logic [WORD_BYTES-1:0][IDX_W-1:0] a_idx, b_idx, clr_idx;
  logic [WORD_W-1:0] a_mem_bytes, b_mem_bytes;
  logic [WORD_W-1:0] a_wr_bytes, b_wr_unused;
  logic [WORD_W-1:0] a_rword, b_rword;
  logic              a_oor, b_oor;
  logic              a_acc, b_acc, a_wr, clearing;

  // Byte addresses wrap only for out-of-range accesses, whose data is discarded.
  for (genvar i = 0; i < WORD_BYTES; i++) begin : g_idx
    logic [ADDR_W-1:0] a_full, b_full, c_full;
    assign a_full     = a_addr + ADDR_W'(i);
    assign b_full     = b_addr + ADDR_W'(i);
    assign c_full     = clr_q  + ADDR_W'(i);
    assign a_idx[i]   = a_full[IDX_W-1:0];
    assign b_idx[i]   = b_full[IDX_W-1:0];
    assign clr_idx[i] = c_full[IDX_W-1:0];
    assign a_mem_bytes[i*BYTE_W +: BYTE_W] = mem[a_idx[i]];
    assign b_mem_bytes[i*BYTE_W +: BYTE_W] = mem[b_idx[i]];
  end

  wsn_mem_lane #(
    .MEM_DEPTH (MEM_DEPTH),
    .BYTE_W    (BYTE_W),
    .WORD_BYTES(WORD_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_lane_a (
    .addr     (a_addr),
    .wdata    (a_wdata),
    .mem_bytes(a_mem_bytes),
    .wr_bytes (a_wr_bytes),
    .rword    (a_rword),
    .oor      (a_oor)
  );

  wsn_mem_lane #(
    .MEM_DEPTH (MEM_DEPTH),
    .BYTE_W    (BYTE_W),
    .WORD_BYTES(WORD_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_lane_b (
    .addr     (b_addr),
    .wdata    ('0),
    .mem_bytes(b_mem_bytes),
    .wr_bytes (b_wr_unused),
    .rword    (b_rword),
    .oor      (b_oor)
  );

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_q == ADDR_W'(MEM_DEPTH - WORD_BYTES)) state_d = ST_READY;
      end
      ST_READY: begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end
      default: state_d = state_q;
    endcase
  end

  assign a_acc    = a_req && a_ready;
  assign b_acc    = b_req && b_ready;
  assign a_wr     = a_acc && a_we && !a_oor;
  assign clearing = (state_q == ST_CLEAR) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_q    <= '0;
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      a_err    <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_q <= clr_q + ADDR_W'(WORD_BYTES);

      a_rvalid <= a_acc && !a_we;
      a_err    <= a_acc && a_oor;
      // rdata follows accepted reads; any out-of-range access forces it to zero.
      if (a_acc && (!a_we || a_oor)) a_rdata <= a_oor ? '0 : a_rword;

      b_rvalid <= b_acc;
      b_err    <= b_acc && b_oor;
      if (b_acc) b_rdata <= b_oor ? '0 : b_rword;
    end
  end

  // Non-blocking update: a B read in the same cycle sees the pre-write bytes.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (clearing)  mem[clr_idx[i]] <= '0;
      else if (a_wr) mem[a_idx[i]]   <= a_wr_bytes[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: tb/tb_wsn_mem_dp.sv
module tb_wsn_mem_dp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
  logic [10:0] a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err, busy;
  logic [15:0] a_rdata, b_rdata;

  logic        reset4 = 1'b1;
  logic        a4_req = 1'b0, a4_we = 1'b0, b4_req = 1'b0;
  logic [5:0]  a4_addr = '0, b4_addr = '0;
  logic [31:0] a4_wdata = '0;
  logic        a4_ready, a4_rvalid, a4_err, b4_ready, b4_rvalid, b4_err, busy4;
  logic [31:0] a4_rdata, b4_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: plain byte array, 16-bit big-endian words.
  logic [7:0]  model_mem [2048];
  logic [15:0] exp_a_d, exp_b_d;

  always #5 clock = ~clock;

  wsn_mem_dp dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_addr(b_addr),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .busy(busy)
  );

  wsn_mem_dp #(.MEM_DEPTH(64), .WORD_BYTES(4), .ADDR_W(6)) dut4 (
    .clock(clock), .reset(reset4),
    .a_req(a4_req), .a_we(a4_we), .a_addr(a4_addr), .a_wdata(a4_wdata),
    .a_ready(a4_ready), .a_rvalid(a4_rvalid), .a_rdata(a4_rdata), .a_err(a4_err),
    .b_req(b4_req), .b_addr(b4_addr),
    .b_ready(b4_ready), .b_rvalid(b4_rvalid), .b_rdata(b4_rdata), .b_err(b4_err),
    .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_oor(input int addr);
    return (addr + 2) > 2048;
  endfunction

  function automatic logic [15:0] model_rd(input int addr);
    return {model_mem[addr], model_mem[addr+1]};
  endfunction

  task automatic model_clear();
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    exp_a_d = '0;
    exp_b_d = '0;
  endtask

  // One cycle on both ports of the main DUT, checked against the model.
  task automatic cyc(input bit ar, input bit aw, input int aa, input logic [15:0] ad,
                     input bit br, input int ba);
    bit ea_v, ea_e, eb_v, eb_e;
    a_req = ar; a_we = aw; a_addr = aa[10:0]; a_wdata = ad;
    b_req = br; b_addr = ba[10:0];
    ea_v = ar && !aw;
    ea_e = ar && model_oor(aa);
    if (ar && model_oor(aa)) exp_a_d = '0;
    else if (ar && !aw)      exp_a_d = model_rd(aa);
    eb_v = br;
    eb_e = br && model_oor(ba);
    if (br) exp_b_d = model_oor(ba) ? 16'h0000 : model_rd(ba);
    @(posedge clock); #1;
    a_req = 1'b0; b_req = 1'b0;
    chk("a_ready", a_ready, 1);
    chk("a_rvalid", a_rvalid, ea_v);
    chk("a_err", a_err, ea_e);
    chk("a_rdata", a_rdata, exp_a_d);
    chk("b_rvalid", b_rvalid, eb_v);
    chk("b_err", b_err, eb_e);
    chk("b_rdata", b_rdata, exp_b_d);
    if (ar && aw && !model_oor(aa)) begin
      model_mem[aa]   = ad[15:8];
      model_mem[aa+1] = ad[7:0];
    end
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 3))
      0:       return $urandom_range(2040, 2047);
      1:       return $urandom_range(16'h684, 16'h68F);
      default: return $urandom_range(0, 2047);
    endcase
  endfunction

  initial begin
    int  n;
    bit  saw_b;
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_b_err", b_err, 0);

    // Sweep length with B requests ignored while clearing
    reset = 1'b0;
    b_req = 1'b1; b_addr = 11'h000;
    n = 0; saw_b = 0;
    while (busy && n < 5000) begin
      @(posedge clock); #1;
      n++;
      if (b_rvalid) saw_b = 1;
    end
    b_req = 1'b0;
    chk("sweep_len", n, 1024);
    chk("b_ignored_clear", saw_b, 0);
    model_clear();

    // Endianness, unaligned write
    cyc(1, 1, 'h009, 16'h1234, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h008);
    cyc(0, 0, 0, 0, 1, 'h009);
    chk("endian_009", b_rdata, 16'h1234);
    cyc(0, 0, 0, 0, 1, 'h00A);
    chk("endian_00A", b_rdata, 16'h3400);

    // Collision: B sees the old bytes, then the new ones
    cyc(1, 1, 'h688, 16'h0005, 0, 0);
    cyc(1, 1, 'h688, 16'hBEEF, 1, 'h688);
    chk("collide_old", b_rdata, 16'h0005);
    cyc(0, 0, 0, 0, 1, 'h688);
    chk("collide_new", b_rdata, 16'hBEEF);
    cyc(1, 0, 'h688, 0, 1, 'h688);
    chk("same_addr_rd", a_rdata, b_rdata);

    // Bounds
    cyc(1, 1, 'h7FE, 16'h5A5A, 0, 0);
    cyc(1, 0, 'h7FF, 0, 0, 0);
    cyc(1, 1, 'h7FF, 16'hFFFF, 1, 'h7FF);
    cyc(1, 0, 'h7FE, 0, 0, 0);
    chk("oor_wr_untouched", a_rdata, 16'h5A5A);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1), pick_addr(), 16'($urandom),
          $urandom_range(0, 1), pick_addr());

    // Clear sweep after dirtying memory; reset cancels a pending read
    cyc(1, 1, 'h000, 16'hABAB, 0, 0);
    cyc(1, 1, 'h7FE, 16'hABAB, 0, 0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'h000;
    reset = 1'b1;
    @(posedge clock); #1;
    a_req = 1'b0;
    chk("rst_cancel_rvalid", a_rvalid, 0);
    chk("rst_busy2", busy, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (500) @(posedge clock);
    #1;
    chk("busy_mid_sweep", busy, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    wait_sweep(n);
    chk("sweep_restart_len", n, 1024);
    model_clear();
    cyc(1, 0, 'h000, 0, 1, 'h7FE);
    chk("cleared_000", a_rdata, 16'h0000);
    chk("cleared_7FE", b_rdata, 16'h0000);

    // 4-byte word, 64-byte instance
    reset4 = 1'b0;
    n = 0;
    while (busy4 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    chk("w4_sweep_len", n, 16);
    a4_req = 1'b1; a4_we = 1'b1; a4_addr = 6'h3C; a4_wdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    chk("w4_wr_rvalid", a4_rvalid, 0);
    chk("w4_wr_err", a4_err, 0);
    a4_we = 1'b0;
    b4_req = 1'b1; b4_addr = 6'h3D;
    @(posedge clock); #1;
    a4_req = 1'b0; b4_req = 1'b0;
    chk("w4_rd_rvalid", a4_rvalid, 1);
    chk("w4_rd_data", a4_rdata, 32'hDEADBEEF);
    chk("w4_oor_err", b4_err, 1);
    chk("w4_oor_rvalid", b4_rvalid, 1);
    chk("w4_oor_data", b4_rdata, 0);
    a4_req = 1'b1; a4_addr = 6'h3D;
    b4_req = 1'b1; b4_addr = 6'h3E;
    @(posedge clock); #1;
    a4_req = 1'b0; b4_req = 1'b0;
    chk("w4_a_oor_err", a4_err, 1);
    chk("w4_a_oor_data", a4_rdata, 0);
    chk("w4_b_oor_err", b4_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
